// File: rtl/key_debounce_pkg.sv
// Shared types and 12 MHz board timing defaults for the key debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } hold_state_e;

  localparam int DEF_STABLE_CNT = 240000;   // 20 ms
  localparam int DEF_CNT_W      = 18;
  localparam int DEF_REPEAT_DLY = 6000000;  // 0.5 s
  localparam int DEF_REPEAT_PER = 1200000;  // 100 ms
  localparam int DEF_HOLD_W     = 23;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, stability qualifier and auto-repeat hold FSM.
// Level/pulses register STABLE_CNT+1 edges after a clean pin edge; no backpressure.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ACTIVE_LOW = 1,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER,
  parameter int HOLD_W     = DEF_HOLD_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam logic              IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam bit                REPEAT_EN = (REPEAT_DLY != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
  localparam logic [HOLD_W-1:0] PER_LAST  = HOLD_W'(REPEAT_PER - 1);

  logic              sync1_q, sync2_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              level_q, press_q, release_q, repeat_q;
  hold_state_e       state_q;
  logic [HOLD_W-1:0] hold_q;

  logic s, differ, flip_d, press_d, release_d;

  always_comb begin
    s         = sync2_q ^ IDLE_LVL;
    differ    = (s != level_q);
    flip_d    = differ && (cnt_q == CNT_LAST);
    press_d   = flip_d && s;
    release_d = flip_d && !s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      press_q   <= press_d;
      release_q <= release_d;
      // One cycle of agreement throws away any partial qualification.
      if (!differ) begin
        cnt_q <= '0;
      end else if (flip_d) begin
        cnt_q   <= '0;
        level_q <= s;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // The hold FSM keys off the same-edge press/release events so the first
  // repeat lands exactly REPEAT_DLY cycles after the press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (release_d || !REPEAT_EN) begin
        state_q <= IDLE;
        hold_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (press_d) begin
              state_q <= DELAY;
              hold_q  <= '0;
            end
          end
          DELAY: begin
            if (hold_q == DLY_LAST) begin
              repeat_q <= 1'b1;
              hold_q   <= '0;
              state_q  <= REPEAT;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          REPEAT: begin
            if (hold_q == PER_LAST) begin
              repeat_q <= 1'b1;
              hold_q   <= '0;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            hold_q  <= '0;
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_n.sv
// N independent debounced key channels with press/release/auto-repeat pulses.
// All outputs registered, STABLE_CNT+1 edges after a clean pin edge; no backpressure.
module key_debounce_n
  import key_debounce_pkg::*;
#(
  parameter int N          = 4,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ACTIVE_LOW = 1,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER,
  parameter int HOLD_W     = DEF_HOLD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_repeat
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    key_debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W),
      .ACTIVE_LOW (ACTIVE_LOW),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER),
      .HOLD_W     (HOLD_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_i     (key[g]),
      .level_o   (key_level[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g]),
      .repeat_o  (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_n.sv
// Directed-vector bench: main instance (active-low, repeat on) plus an
// active-high instance with auto-repeat disabled.
module tb_key_debounce_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key = 2'b11;
  logic [1:0] key_level, key_press, key_release, key_repeat;

  logic       rst2 = 1'b1;
  logic [0:0] key2 = 1'b0;
  logic [0:0] lvl2, prs2, rel2, rep2;

  always #5 clk = ~clk;

  key_debounce_n #(
    .N(2), .STABLE_CNT(4), .ACTIVE_LOW(1), .REPEAT_DLY(10), .REPEAT_PER(3)
  ) u_dut (
    .clk(clk), .rst(rst), .key(key),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );

  key_debounce_n #(
    .N(1), .STABLE_CNT(4), .ACTIVE_LOW(0), .REPEAT_DLY(0), .REPEAT_PER(3)
  ) u_dis (
    .clk(clk), .rst(rst2), .key(key2),
    .key_level(lvl2), .key_press(prs2),
    .key_release(rel2), .key_repeat(rep2)
  );

  typedef struct {
    logic       rst;
    logic [1:0] key;
    logic [1:0] lvl, prs, rel, rep;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [1:0] k, input logic [1:0] lv,
                     input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] rp,
                     input int times = 1);
    vec_t v;
    v.rst = r; v.key = k; v.lvl = lv; v.prs = pr; v.rel = rl; v.rep = rp;
    for (int i = 0; i < times; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] lv,
                       input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] rp);
    n_vec++;
    if ({key_level, key_press, key_release, key_repeat} !== {lv, pr, rl, rp}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got lvl=%b prs=%b rel=%b rep=%b, want lvl=%b prs=%b rel=%b rep=%b",
               name, idx, key_level, key_press, key_release, key_repeat, lv, pr, rl, rp);
    end
  endtask

  task automatic check2(input string name, input int idx, input logic lv,
                        input logic pr, input logic rl, input logic rp);
    n_vec++;
    if ({lvl2, prs2, rel2, rep2} !== {lv, pr, rl, rp}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got lvl=%b prs=%b rel=%b rep=%b, want lvl=%b prs=%b rel=%b rep=%b",
               name, idx, lvl2, prs2, rel2, rep2, lv, pr, rl, rp);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      key = tbl[i].key;
      @(posedge clk);
      #1;
      check(name, i, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rep);
    end
    tbl.delete();
  endtask

  initial begin
    // Reset, clean press on ch0 (pulse 5 edges after sampling), release before first repeat.
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 3);
    add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    run_table("clean");

    // Bounce with a 2-cycle period, then settle low: single press 5 edges later.
    for (int i = 0; i < 20; i++)
      add(0, {1'b1, (i % 2 == 1)}, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("bounce");

    // Reset one cycle while ch0 is repeating; key still held gives a fresh press.
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 9);
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("rst_hold");

    // Independence and auto-repeat: ch0 pressed at 0, ch1 at 1; released at 40/41.
    // Repeats at P+10, P+13, ...; the one due on the release edge is suppressed.
    begin
      int p[2];
      int r[2];
      logic [1:0] lv, pr, rl, rp;
      p[0] = 5;  p[1] = 6;
      r[0] = 45; r[1] = 46;
      for (int c = 0; c <= 50; c++) begin
        key[0] = (c >= 0 && c < 40) ? 1'b0 : 1'b1;
        key[1] = (c >= 1 && c < 41) ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 2; ch++) begin
          lv[ch] = (c >= p[ch]) && (c < r[ch]);
          pr[ch] = (c == p[ch]);
          rl[ch] = (c == r[ch]);
          rp[ch] = (c >= p[ch] + 10) && (c < r[ch]) && ((c - p[ch] - 10) % 3 == 0);
        end
        check("indep", c, lv, pr, rl, rp);
      end
    end

    // Active-high pin, auto-repeat disabled: one press, one release, never a repeat.
    rst2 = 1'b1;
    key2 = 1'b0;
    @(posedge clk);
    #1;
    check2("dis_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst2 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      key2 = (c < 50) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      check2("dis", c, (c >= 5) && (c < 55), (c == 5), (c == 55), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
